// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and helpers for the matrix-keypad scanner.
//   state_t       - scanner FSM states
//   ROWS_IDLE     - row sample with no key pressed (rows are active-low)
//   col_onehot_n  - active-low one-hot column strobe for a column index
package keypad_pkg;

  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [ROW_W-1:0] ROWS_IDLE = 4'b1111;

  function automatic logic [COL_W-1:0] col_onehot_n(input logic [IDX_W-1:0] idx);
    logic [COL_W-1:0] strobe;
    strobe      = '1;
    strobe[idx] = 1'b0;
    return strobe;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad-side and key-output signals of the scanner.
//   row_in     - keypad rows, active-low, asynchronous
//   col_select - active-low one-hot column strobe
//   key_code   - last accepted key (row*4 + col)
//   key_valid  - one-cycle pulse per accepted press
//   key_held   - accepted key not yet released
// master: the scanner; slave: keypad model / key consumer.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [ROW_W-1:0]  row_in;
  logic [COL_W-1:0]  col_select;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;

  modport master (
    input  row_in,
    output col_select,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_select,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_tick.sv
// keypad_tick: free-running prescaler, one-cycle tick every SCAN_DIV cycles.
//   clk, rst - clock, synchronous active-high reset
//   tick     - high for one cycle while the count sits at SCAN_DIV-1
module keypad_tick #(
  parameter int unsigned SCAN_DIV = 125000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(SCAN_DIV - 2);

  logic [CW-1:0] count;

  // tick is registered one count early so it coincides with the terminal count
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= (count == LAST) ? '0 : count + CW'(1);
      tick  <= (count == PRE);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces, and reports
// one key at a time.
//   clk, rst - clock, synchronous active-high reset
//   bus      - keypad_scanner_if.master (row_in in; col_select, key_code,
//              key_valid, key_held out)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 125000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  keypad_scanner_if.master    bus
);

  localparam logic [CNT_W-1:0] DEB_N = CNT_W'(DEBOUNCE_SCANS);

  logic [ROW_W-1:0]  sync1, rs;
  logic              tick;
  state_t            state, state_d;
  logic [IDX_W-1:0]  col, col_d;
  logic [IDX_W-1:0]  cand_row, cand_row_d;
  logic [IDX_W-1:0]  cand_col, cand_col_d;
  logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
  logic [IDX_W-1:0]  row_idx;
  logic              key_present;
  logic              accept, release_done;
  logic [CODE_W-1:0] key_code_d;
  logic              key_held_d, key_valid_d;
  logic [COL_W-1:0]  col_select_d;

  keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer for the asynchronous rows
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= ROWS_IDLE;
      rs    <= ROWS_IDLE;
    end else begin
      sync1 <= bus.row_in;
      rs    <= sync1;
    end
  end

  // Priority encoder: lowest-numbered low row wins
  always_comb begin
    row_idx     = '0;
    key_present = (rs != ROWS_IDLE);
    for (int i = ROW_W - 1; i >= 0; i--) begin
      if (!rs[i]) row_idx = IDX_W'(i);
    end
  end

  assign cnt_inc = (cnt == DEB_N) ? cnt : cnt + CNT_W'(1);

  // State register with its datapath companions
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCAN;
      col      <= '0;
      cand_row <= '0;
      cand_col <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      col      <= col_d;
      cand_row <= cand_row_d;
      cand_col <= cand_col_d;
      cnt      <= cnt_d;
    end
  end

  // Next-state logic; everything moves only on a scan tick
  always_comb begin
    state_d      = state;
    col_d        = col;
    cand_row_d   = cand_row;
    cand_col_d   = cand_col;
    cnt_d        = cnt;
    accept       = 1'b0;
    release_done = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (!key_present) begin
            col_d = col + IDX_W'(1);
          end else begin
            cand_row_d = row_idx;
            cand_col_d = col;
            cnt_d      = CNT_W'(1);
            if (DEB_N == CNT_W'(1)) begin
              accept  = 1'b1;
              state_d = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (key_present && (row_idx == cand_row)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_N) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end else begin
            cnt_d   = '0;
            state_d = SCAN;
            col_d   = col + IDX_W'(1);
          end
        end
        HELD: begin
          // Only the accepted row matters; other rows are ignored
          if (rs[cand_row]) begin
            if (DEB_N == CNT_W'(1)) begin
              release_done = 1'b1;
              cnt_d        = '0;
              state_d      = SCAN;
              col_d        = col + IDX_W'(1);
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (rs[cand_row]) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_N) begin
              release_done = 1'b1;
              cnt_d        = '0;
              state_d      = SCAN;
              col_d        = col + IDX_W'(1);
            end
          end else begin
            cnt_d   = '0;
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Output decode feeding the output registers
  always_comb begin
    key_code_d   = bus.key_code;
    key_held_d   = bus.key_held;
    key_valid_d  = accept;
    col_select_d = col_onehot_n(col_d);
    if (accept) begin
      key_code_d = {cand_row_d, cand_col_d};
      key_held_d = 1'b1;
    end
    if (release_done) key_held_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.col_select <= col_onehot_n('0);
      bus.key_code   <= '0;
      bus.key_valid  <= 1'b0;
      bus.key_held   <= 1'b0;
    end else begin
      bus.col_select <= col_select_d;
      bus.key_code   <= key_code_d;
      bus.key_valid  <= key_valid_d;
      bus.key_held   <= key_held_d;
    end
  end

endmodule
